pkt_mux_4x1: RTL and testbench



---
 rtl/mux_pkg.sv | 13 +
 rtl/pkt_mux_4x1_if.sv | 29 ++
 rtl/rr_arbiter_4.sv | 28 ++
 rtl/pkt_mux_4x1.sv | 116 +++++++++++
 tb/tb_pkt_mux_4x1.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 4-channel packet mux/demux pair.
// The sel encoding here is common to both directions.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

endpackage

// File: rtl/pkt_mux_4x1_if.sv
// Stream bundle for pkt_mux_4x1: four valid/ready input channels and one tagged output.
// The slave modport is the mux side; the master modport is the upstream/downstream side.
interface pkt_mux_4x1_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_last;
    logic [SEL_W-1:0]        out_sel;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

endinterface

// File: rtl/rr_arbiter_4.sv
// Combinational round-robin pick among four requests, scanning upward from ptr with wrap.
module rr_arbiter_4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + i[SEL_W-1:0];
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/pkt_mux_4x1.sv
// Four-to-one packet mux: round-robin between packets, no interleaving within one,
// single registered output stage tagged with the source channel.
//
//   state | meaning
//   IDLE  | between packets; round-robin grant from ptr
//   LOCK  | mid-packet; only lock_ch may transfer until its last beat
module pkt_mux_4x1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pkt_mux_4x1_if.slave    bus
);

    mux_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  lock_q, lock_d;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_last_q;
    logic [SEL_W-1:0]  out_sel_q;

    logic              load_en;
    logic              xfer;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] in_ready_w;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;

    assign load_en = !out_valid_q | bus.out_ready;

    always_comb begin
        req = bus.in_valid;
        if (state_q == LOCK) begin
            req = bus.in_valid & (NUM_CH'(1) << lock_q);
        end
    end

    rr_arbiter_4 u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // rst_n gates ready so no upstream beat is consumed while the output stage is held clear.
    assign in_ready_w   = grant & {NUM_CH{load_en & rst_n}};
    assign bus.in_ready = in_ready_w;
    assign xfer         = |(bus.in_valid & in_ready_w);
    assign sel_data     = bus.in_data[grant_idx*WIDTH +: WIDTH];
    assign sel_last     = bus.in_last[grant_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (sel_last) begin
                        ptr_d = grant_idx + 2'd1;
                    end else begin
                        state_d = LOCK;
                        lock_d  = grant_idx;
                    end
                end
                LOCK: begin
                    if (sel_last) begin
                        state_d = IDLE;
                        ptr_d   = lock_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
            out_sel_q   <= grant_idx;
        end else if (load_en) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_pkt_mux_4x1.sv
// Bench for pkt_mux_4x1: directed packet scenarios plus random traffic,
// all checked every cycle against a packet-level model of the mux.
module tb_pkt_mux_4x1;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pkt_mux_4x1_if #(.WIDTH(W)) bus ();

    pkt_mux_4x1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an owner channel holds the output between first and last beat of a packet.
    int         m_ptr;
    int         m_owner;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    int         m_sel;
    logic [3:0] last_hs;

    always @(negedge clk) begin
        int         g;
        logic       can_load;
        logic [3:0] exp_rdy;
        if (!rst_n) begin
            m_ptr   = 0;
            m_owner = -1;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_last  = 1'b0;
            m_sel   = 0;
            last_hs = 4'b0000;
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_out_data", int'(bus.out_data), 0);
            check("rst_in_ready", int'(bus.in_ready), 0);
        end else begin
            check("mdl_out_valid", int'(bus.out_valid), int'(m_valid));
            check("mdl_out_data", int'(bus.out_data), int'(m_data));
            check("mdl_out_last", int'(bus.out_last), int'(m_last));
            check("mdl_out_sel", int'(bus.out_sel), m_sel);
            g = -1;
            if (m_owner >= 0) begin
                if (bus.in_valid[m_owner]) g = m_owner;
            end else begin
                for (int j = 0; j < 4; j++) begin
                    if (g < 0 && bus.in_valid[(m_ptr + j) % 4]) g = (m_ptr + j) % 4;
                end
            end
            can_load = !m_valid || bus.out_ready;
            exp_rdy  = (can_load && g >= 0) ? (4'b0001 << g) : 4'b0000;
            check("mdl_in_ready", int'(bus.in_ready), int'(exp_rdy));
            last_hs = bus.in_valid & bus.in_ready;
            if (exp_rdy != 4'b0000) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[g*W +: W];
                m_last  = bus.in_last[g];
                m_sel   = g;
                if (bus.in_last[g]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % 4;
                end else begin
                    m_owner = g;
                end
            end else if (can_load) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
        bus.in_valid[ch]       = v;
        bus.in_data[ch*W +: W] = d;
        bus.in_last[ch]        = l;
    endtask

    task automatic expect_out(input string name, input int sel, input int data, input int last);
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_sel"}, int'(bus.out_sel), sel);
        check({name, "_data"}, int'(bus.out_data), data);
        check({name, "_last"}, int'(bus.out_last), last);
    endtask

    int left [4];

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 4'hF;
        bus.in_last   = 4'hF;
        bus.in_data   = 32'hA3A2A1A0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("reset_in_ready", int'(bus.in_ready), 0);
        check("reset_out_sel", int'(bus.out_sel), 0);

        // Single-beat packets on all channels: strict 0,1,2,3 rotation.
        rst_n = 1'b1;
        #1;
        check("first_grant", int'(bus.in_ready), 4'b0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("rr_single", i, 8'hA0 + i, 1);
            if (i == 3) bus.in_valid = 4'h0;
        end
        tick();

        // Channel 2 packet of three beats must not be split by channel 1.
        set_ch(1, 1'b1, 8'h11, 1'b1);
        tick();
        expect_out("lock_pre", 1, 8'h11, 1);
        set_ch(2, 1'b1, 8'h20, 1'b0);
        tick();
        expect_out("lock_b0", 2, 8'h20, 0);
        set_ch(2, 1'b1, 8'h21, 1'b0);
        tick();
        expect_out("lock_b1", 2, 8'h21, 0);
        set_ch(2, 1'b1, 8'h22, 1'b1);
        tick();
        expect_out("lock_b2", 2, 8'h22, 1);
        set_ch(2, 1'b0, 8'h00, 1'b0);
        tick();
        expect_out("lock_after", 1, 8'h11, 1);
        set_ch(1, 1'b0, 8'h00, 1'b0);
        tick();

        // Backpressure: output holds 5C, no input accepted, then 5D follows exactly once.
        set_ch(0, 1'b1, 8'h5C, 1'b1);
        bus.out_ready = 1'b0;
        tick();
        set_ch(0, 1'b1, 8'h5D, 1'b1);
        for (int k = 0; k < 4; k++) begin
            expect_out("bp_hold", 0, 8'h5C, 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
            tick();
        end
        expect_out("bp_hold", 0, 8'h5C, 1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(bus.in_ready), 4'b0001);
        tick();
        expect_out("bp_resume", 0, 8'h5D, 1);
        set_ch(0, 1'b0, 8'h00, 1'b0);
        tick();
        check("bp_no_dup", int'(bus.out_valid), 0);

        // Pointer wrap: after channel 3 the scan restarts at channel 0.
        set_ch(3, 1'b1, 8'h33, 1'b1);
        tick();
        expect_out("wrap_ch3", 3, 8'h33, 1);
        set_ch(0, 1'b1, 8'h30, 1'b1);
        set_ch(3, 1'b1, 8'h34, 1'b1);
        tick();
        expect_out("wrap_ch0", 0, 8'h30, 1);
        set_ch(0, 1'b0, 8'h00, 1'b0);
        tick();
        expect_out("wrap_ch3b", 3, 8'h34, 1);
        set_ch(3, 1'b0, 8'h00, 1'b0);
        tick();

        // Locked channel stalls: channel 0 stays blocked until channel 1 finishes.
        set_ch(1, 1'b1, 8'h31, 1'b0);
        tick();
        expect_out("stall_b0", 1, 8'h31, 0);
        set_ch(1, 1'b0, 8'h31, 1'b0);
        set_ch(0, 1'b1, 8'h0A, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_idle", int'(bus.out_valid), 0);
            check("stall_ready", int'(bus.in_ready), 0);
        end
        set_ch(1, 1'b1, 8'h32, 1'b1);
        tick();
        expect_out("stall_b1", 1, 8'h32, 1);
        set_ch(1, 1'b0, 8'h00, 1'b0);
        tick();
        expect_out("stall_ch0", 0, 8'h0A, 1);
        set_ch(0, 1'b0, 8'h00, 1'b0);
        tick();

        // Random packets with random backpressure; the model checks every cycle.
        for (int i = 0; i < 4; i++) left[i] = $urandom_range(1, 4);
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (last_hs[i]) begin
                    left[i]--;
                    if (left[i] == 0) left[i] = $urandom_range(1, 4);
                end
                set_ch(i, ($urandom % 4) != 0, 8'($urandom), left[i] == 1);
            end
            bus.out_ready = ($urandom % 4) != 0;
        end

        // Reset mid-stream clears the output at once; first grant afterwards is channel 0.
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_data", int'(bus.out_data), 0);
        check("midrst_out_last", int'(bus.out_last), 0);
        check("midrst_out_sel", int'(bus.out_sel), 0);
        check("midrst_in_ready", int'(bus.in_ready), 0);
        tick();
        tick();
        bus.in_valid  = 4'hF;
        bus.in_last   = 4'hF;
        bus.in_data   = 32'hA3A2A1A0;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", int'(bus.in_ready), 4'b0001);
        tick();
        expect_out("post_rst_out", 0, 8'hA0, 1);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
